drbg_sequence_receiver: RTL and testbench

- Recovers the transmitter's 32-bit DRBG sequence number from a designated blanking line of the incoming video stream.
- Checks the recovered number and presents it as `sequence_external` / `sequence_external_valid` to the downstream DRBG synchroniser.
- One frame is decoded per field; a failed decode publishes nothing and raises an error indication.

---
 rtl/drbg_sequence_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_drbg_sequence_receiver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drbg_sequence_receiver.sv
// Recovers a 48-bit sequence frame (preamble, 32-bit number, CRC-8) from one blanking line per field.
// Optional CRC checking is compiled in with `define DRBG_SEQ_RX_CRC_EN.
module drbg_sequence_receiver #(
    parameter int LINE_INDEX   = 10,
    parameter int PIXEL_OFFSET = 16,
    parameter int BIT_PIXELS   = 5,
    parameter int THRESHOLD    = 128,
    parameter int VALID_HOLD   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        field_start,
    input  logic        line_start,
    input  logic        pixel_valid,
    input  logic [7:0]  pixel_data,
    output logic [31:0] sequence_external,
    output logic        sequence_external_valid,
    output logic        rx_error,
    output logic [15:0] error_count
);

    typedef enum logic [3:0] {
        IDLE, LINE_WAIT, SKIP, PREAMBLE, DATA, CRC, CHECK, PUBLISH, FAIL
    } state_t;

    state_t      state;
    logic [9:0]  line_cnt;
    logic [9:0]  line_next;
    logic [15:0] skip_cnt;
    logic [7:0]  pix_cnt;
    logic [7:0]  vote_cnt;
    logic [7:0]  votes_total;
    logic [5:0]  bit_cnt;
    logic [31:0] shift;
    logic [31:0] shift_next;
    logic [31:0] data_reg;
    logic [15:0] hold_cnt;
    logic        hold_gap;
    logic        vote;
    logic        bit_done;
    logic        bit_value;
    logic        collecting;
    logic        abort;
    logic        truncate;
    logic        crc_ok;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        line_next = line_cnt;
        if (field_start)
            line_next = 10'd0;
        else if (line_start && line_cnt != 10'd1023)
            line_next = line_cnt + 10'd1;

        vote        = ({1'b0, pixel_data} >= 9'(THRESHOLD));
        votes_total = vote_cnt + {7'd0, vote};
        bit_done    = pixel_valid && (pix_cnt == 8'(BIT_PIXELS - 1));
        bit_value   = ({votes_total, 1'b0} > 9'(BIT_PIXELS));
        shift_next  = {shift[30:0], bit_value};

        collecting = (state inside {SKIP, PREAMBLE, DATA, CRC});
        // field_start outranks line_start; PUBLISH/FAIL always finish their single cycle
        abort      = field_start && (state != PUBLISH) && (state != FAIL);
        truncate   = line_start && collecting;
    end

`ifdef DRBG_SEQ_RX_CRC_EN
    logic [7:0] crc_calc;
    logic [7:0] crc_step;

    // Bit-serial CRC-8, polynomial 0x07, MSB first over the 32 data bits
    always_comb begin
        crc_step = {crc_calc[6:0], 1'b0} ^ ((crc_calc[7] ^ bit_value) ? 8'h07 : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (reset || state == PREAMBLE)
            crc_calc <= 8'h00;
        else if (state == DATA && bit_done)
            crc_calc <= crc_step;
    end

    // After all 48 bits the received CRC byte sits in the low byte of the shifter
    assign crc_ok = (shift[7:0] == crc_calc);
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            line_cnt                <= 10'd0;
            skip_cnt                <= 16'd0;
            pix_cnt                 <= 8'd0;
            vote_cnt                <= 8'd0;
            bit_cnt                 <= 6'd0;
            shift                   <= 32'd0;
            data_reg                <= 32'd0;
            sequence_external       <= 32'd0;
            sequence_external_valid <= 1'b0;
            hold_cnt                <= 16'd0;
            hold_gap                <= 1'b0;
            rx_error                <= 1'b0;
            error_count             <= 16'd0;
        end else begin
            line_cnt <= line_next;
            rx_error <= 1'b0;

            // A publish during an active hold leaves one low cycle before re-raising
            if (hold_gap) begin
                hold_gap                <= 1'b0;
                sequence_external_valid <= 1'b1;
                hold_cnt                <= 16'(VALID_HOLD);
            end else if (sequence_external_valid) begin
                if (hold_cnt <= 16'd1)
                    sequence_external_valid <= 1'b0;
                else
                    hold_cnt <= hold_cnt - 16'd1;
            end

            if (abort) begin
                state <= LINE_WAIT;
            end else if (truncate) begin
                state       <= FAIL;
                rx_error    <= 1'b1;
                error_count <= sat_inc(error_count);
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    LINE_WAIT: begin
                        if (line_start && line_next == 10'(LINE_INDEX)) begin
                            state    <= SKIP;
                            skip_cnt <= 16'd0;
                        end
                    end
                    SKIP: begin
                        if (pixel_valid) begin
                            if (skip_cnt == 16'(PIXEL_OFFSET - 1)) begin
                                state    <= PREAMBLE;
                                pix_cnt  <= 8'd0;
                                vote_cnt <= 8'd0;
                                bit_cnt  <= 6'd0;
                            end else begin
                                skip_cnt <= skip_cnt + 16'd1;
                            end
                        end
                    end
                    PREAMBLE, DATA, CRC: begin
                        if (bit_done) begin
                            pix_cnt  <= 8'd0;
                            vote_cnt <= 8'd0;
                            shift    <= shift_next;
                            bit_cnt  <= bit_cnt + 6'd1;
                            // bit_cnt runs 0..47 across the whole frame
                            if (state == PREAMBLE && bit_cnt == 6'd7) begin
                                if (shift_next[7:0] == 8'hB4) begin
                                    state <= DATA;
                                end else begin
                                    state       <= FAIL;
                                    rx_error    <= 1'b1;
                                    error_count <= sat_inc(error_count);
                                end
                            end else if (state == DATA && bit_cnt == 6'd39) begin
                                data_reg <= shift_next;
                                state    <= CRC;
                            end else if (state == CRC && bit_cnt == 6'd47) begin
                                state <= CHECK;
                            end
                        end else if (pixel_valid) begin
                            pix_cnt  <= pix_cnt + 8'd1;
                            vote_cnt <= votes_total;
                        end
                    end
                    CHECK: begin
                        if (crc_ok) begin
                            state <= PUBLISH;
                        end else begin
                            state       <= FAIL;
                            rx_error    <= 1'b1;
                            error_count <= sat_inc(error_count);
                        end
                    end
                    PUBLISH: begin
                        state             <= IDLE;
                        sequence_external <= data_reg;
                        if (sequence_external_valid) begin
                            sequence_external_valid <= 1'b0;
                            hold_gap                <= 1'b1;
                        end else begin
                            sequence_external_valid <= 1'b1;
                            hold_cnt                <= 16'(VALID_HOLD);
                        end
                    end
                    FAIL:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_drbg_sequence_receiver.sv
// Directed bench for drbg_sequence_receiver: default instance plus a long-hold instance for overlap.
// Expectations for the bad-CRC frame follow DRBG_SEQ_RX_CRC_EN.
module tb_drbg_sequence_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        field_start;
    logic        line_start;
    logic        pixel_valid;
    logic [7:0]  pixel_data;

    logic [31:0] seq1;
    logic        valid1;
    logic        rx_error1;
    logic [15:0] err_count1;
    logic [31:0] seq2;
    logic        valid2;
    logic        rx_error2;
    logic [15:0] err_count2;

    int compared   = 0;
    int mismatched = 0;
    int err_pulses = 0;
    int valid_cycles = 0;

    always #5 clk = ~clk;

    drbg_sequence_receiver u_rx (
        .clk(clk), .reset(reset), .field_start(field_start), .line_start(line_start),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .sequence_external(seq1), .sequence_external_valid(valid1),
        .rx_error(rx_error1), .error_count(err_count1)
    );

    drbg_sequence_receiver #(
        .LINE_INDEX(1), .PIXEL_OFFSET(2), .BIT_PIXELS(3), .THRESHOLD(128), .VALID_HOLD(400)
    ) u_rx_hold (
        .clk(clk), .reset(reset), .field_start(field_start), .line_start(line_start),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .sequence_external(seq2), .sequence_external_valid(valid2),
        .rx_error(rx_error2), .error_count(err_count2)
    );

    always @(posedge clk) begin
        #1;
        if (rx_error1 === 1'b1) err_pulses++;
        if (valid1 === 1'b1) valid_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic fs, input logic ls, input logic pv, input logic [7:0] pd);
        @(negedge clk);
        field_start = fs;
        line_start  = ls;
        pixel_valid = pv;
        pixel_data  = pd;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'hFF);
    endtask

    task automatic send_bit(input logic b, input int bp, input bit noisy);
        logic v;
        for (int p = 0; p < bp; p++) begin
            v = (noisy && (p == 1 || p == 3)) ? ~b : b;
            if (p == 0) step(1'b0, 1'b0, 1'b1, v ? 8'd128 : 8'd127);
            else        step(1'b0, 1'b0, 1'b1, v ? 8'd220 : 8'd30);
            if (p == 1) step(1'b0, 1'b0, 1'b0, v ? 8'd0 : 8'd255);
        end
    endtask

    task automatic send_field(input logic [47:0] frame, input int line_idx, input int offset,
                              input int bp, input bit noisy, input int nbits);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int l = 1; l < line_idx; l++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            step(1'b0, 1'b0, 1'b1, 8'hFF);
        end
        step(1'b0, 1'b1, 1'b1, 8'h00);
        for (int s = 0; s < offset; s++) begin
            step(1'b0, 1'b0, 1'b1, 8'hFF);
            if (s == 3) step(1'b0, 1'b0, 1'b0, 8'h00);
        end
        for (int i = 0; i < nbits; i++) send_bit(frame[47-i], bp, noisy);
    endtask

    task automatic measure_valid(input bit sel, output int n);
        n = 0;
        while (((sel ? valid2 : valid1) === 1'b1) && n < 1000) begin
            n++;
            idle(1);
        end
    endtask

    // Call right after the last CRC pixel has been driven (edge E follows)
    task automatic check_publish(input string tag, input logic [31:0] exp_seq, input logic [31:0] old_seq);
        int n;
        idle(1);
        chk({tag, "_valid_e0"}, {31'd0, valid1}, 32'd0);
        chk({tag, "_seq_e0"}, seq1, old_seq);
        idle(1);
        chk({tag, "_valid_e1"}, {31'd0, valid1}, 32'd0);
        idle(1);
        chk({tag, "_valid_e2"}, {31'd0, valid1}, 32'd1);
        chk({tag, "_seq_e2"}, seq1, exp_seq);
        measure_valid(1'b0, n);
        chk({tag, "_hold_len"}, n, 32'd4);
    endtask

    localparam logic [47:0] F_GOOD1 = {8'hB4, 32'h0000_0001, 8'h07};
    localparam logic [47:0] F_BADCRC = {8'hB4, 32'h0000_0001, 8'h06};
    localparam logic [47:0] F_BADPRE = {8'hB5, 32'h0000_0001, 8'h07};
    localparam logic [47:0] F_GOOD2 = {8'hB4, 32'h0000_0002, 8'h0E};

    initial begin
        int exp_err;
        int e0;
        int v0;
        int n;
        logic [47:0] fr;

        exp_err     = 0;
        reset       = 1'b1;
        field_start = 1'b0;
        line_start  = 1'b0;
        pixel_valid = 1'b0;
        pixel_data  = 8'h00;
        idle(3);
        chk("reset_seq", seq1, 32'd0);
        chk("reset_valid", {31'd0, valid1}, 32'd0);
        chk("reset_rx_error", {31'd0, rx_error1}, 32'd0);
        chk("reset_err_count", {16'd0, err_count1}, 32'd0);
        reset = 1'b0;
        idle(3);

        // Clean frame, data 1
        e0 = err_pulses;
        send_field(F_GOOD1, 10, 16, 5, 1'b0, 48);
        check_publish("t1", 32'h1, 32'h0);
        chk("t1_no_error", err_pulses - e0, 32'd0);
        chk("t1_err_count", {16'd0, err_count1}, 32'd0);

        // Corrupted CRC byte
        e0 = err_pulses;
        v0 = valid_cycles;
        send_field(F_BADCRC, 10, 16, 5, 1'b0, 48);
        idle(12);
`ifdef DRBG_SEQ_RX_CRC_EN
        exp_err++;
        chk("t2_err_pulse", err_pulses - e0, 32'd1);
        chk("t2_no_publish", valid_cycles - v0, 32'd0);
`else
        chk("t2_err_pulse", err_pulses - e0, 32'd0);
        chk("t2_publish", valid_cycles - v0, 32'd4);
`endif
        chk("t2_err_count", {16'd0, err_count1}, exp_err);
        chk("t2_seq", seq1, 32'h1);

        // Bad preamble: error right after the 8th bit
        v0 = valid_cycles;
        send_field(F_BADPRE, 10, 16, 5, 1'b0, 8);
        idle(1);
        exp_err++;
        chk("t3_rx_error_hi", {31'd0, rx_error1}, 32'd1);
        chk("t3_err_count", {16'd0, err_count1}, exp_err);
        idle(1);
        chk("t3_rx_error_lo", {31'd0, rx_error1}, 32'd0);
        idle(20);
        chk("t3_no_publish", valid_cycles - v0, 32'd0);

        // Truncation after 20 bits, then a good frame with data 2
        fr = F_GOOD2;
        send_field(fr, 10, 16, 5, 1'b0, 20);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        idle(1);
        exp_err++;
        chk("t5_rx_error_hi", {31'd0, rx_error1}, 32'd1);
        chk("t5_err_count", {16'd0, err_count1}, exp_err);
        idle(1);
        chk("t5_rx_error_lo", {31'd0, rx_error1}, 32'd0);
        chk("t5_seq_held", seq1, 32'h1);
        idle(5);
        send_field(F_GOOD2, 10, 16, 5, 1'b0, 48);
        check_publish("t5", 32'h2, 32'h1);
        chk("t5_err_count_after", {16'd0, err_count1}, exp_err);

        // Noisy pixels: two of every five inverted
        e0 = err_pulses;
        send_field(F_GOOD1, 10, 16, 5, 1'b1, 48);
        check_publish("t4", 32'h1, 32'h2);
        chk("t4_no_error", err_pulses - e0, 32'd0);

        // Overlapping publish on the long-hold instance
        idle(5);
        send_field(F_GOOD1, 1, 2, 3, 1'b0, 48);
        idle(2);
        chk("t6_valid_e1", {31'd0, valid2}, 32'd0);
        idle(1);
        chk("t6_valid_e2", {31'd0, valid2}, 32'd1);
        chk("t6_seq_first", seq2, 32'h1);
        send_field(F_GOOD2, 1, 2, 3, 1'b0, 48);
        idle(1);
        chk("t6_still_hold_e0", {31'd0, valid2}, 32'd1);
        chk("t6_seq_old_e0", seq2, 32'h1);
        idle(1);
        chk("t6_still_hold_e1", {31'd0, valid2}, 32'd1);
        idle(1);
        chk("t6_gap_low", {31'd0, valid2}, 32'd0);
        chk("t6_seq_new", seq2, 32'h2);
        idle(1);
        chk("t6_rise_again", {31'd0, valid2}, 32'd1);
        measure_valid(1'b1, n);
        chk("t6_hold_len", n, 32'd400);
        chk("t6_seq_stable", seq2, 32'h2);

        // Reset in the middle of the data bits
        send_field(F_GOOD2, 10, 16, 5, 1'b0, 20);
        reset = 1'b1;
        idle(1);
        chk("rst_seq", seq1, 32'd0);
        chk("rst_valid", {31'd0, valid1}, 32'd0);
        chk("rst_rx_error", {31'd0, rx_error1}, 32'd0);
        chk("rst_err_count", {16'd0, err_count1}, 32'd0);
        chk("rst_hold_seq", seq2, 32'd0);
        reset = 1'b0;
        v0 = valid_cycles;
        fr = F_GOOD2;
        for (int i = 20; i < 48; i++) send_bit(fr[47-i], 5, 1'b0);
        idle(10);
        chk("rst_no_publish", valid_cycles - v0, 32'd0);
        chk("rst_seq_after", seq1, 32'd0);
        chk("rst_err_after", {16'd0, err_count1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
